// File: rtl/snake_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// snake_pkg : shared FSM encodings, default tick periods, period helper
// Rev 1.0
// ============================================================================
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_MOVE  = 3'd3,
    ST_COLL  = 3'd4,
    ST_DRAW  = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  localparam logic [23:0] c_DEF_TICK_PERIOD = 24'd10000000;
  localparam logic [23:0] c_DEF_SPEED_STEP  = 24'd1000000;
  localparam logic [23:0] c_DEF_MIN_PERIOD  = 24'd2000000;

  // Widened to 27 bits so neither the product nor the subtraction can wrap.
  function automatic logic [23:0] calc_period(
    input logic [23:0] base,
    input logic [23:0] step,
    input logic [23:0] floor_v,
    input logic [2:0]  speed
  );
    logic [26:0] dec;
    logic [26:0] base_w;
    dec    = 27'(speed) * 27'(step);
    base_w = {3'b000, base};
    if ((dec >= base_w) || ((base_w - dec) < {3'b000, floor_v}))
      return floor_v;
    else
      return base - dec[23:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tick_timer : 24-bit reloading down-counter, one-cycle tick at zero
// Rev 1.0
// ============================================================================
module tick_timer
  import snake_pkg::*;
#(
  parameter logic [23:0] RESET_LOAD = c_DEF_TICK_PERIOD - 24'd1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [23:0] period_i,
  output logic        tick_o
);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  // Idle cycles keep the counter parked at a fresh reload value.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!run_i) begin
      cnt_d = period_i - 24'd1;
    end else if (cnt_q == 24'd0) begin
      tick_o = 1'b1;
      cnt_d  = period_i - 24'd1;
    end else begin
      cnt_d = cnt_q - 24'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= RESET_LOAD;
    else         cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/game_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// game_tick_scheduler : paces game ticks and sequences clear/move/coll/draw
// Rev 1.0
// ============================================================================
module game_tick_scheduler
  import snake_pkg::*;
#(
  parameter logic [23:0] TICK_PERIOD = c_DEF_TICK_PERIOD,
  parameter logic [23:0] SPEED_STEP  = c_DEF_SPEED_STEP,
  parameter logic [23:0] MIN_PERIOD  = c_DEF_MIN_PERIOD
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [2:0]  speed_i,
  output logic        clear_o,
  output logic        move_start_o,
  input  logic        move_done_i,
  output logic        coll_start_o,
  input  logic        coll_done_i,
  input  logic        coll_hit_i,
  output logic        draw_start_o,
  input  logic        draw_done_i,
  output logic        busy_o,
  output logic        game_over_o,
  output logic        overrun_o,
  output logic [15:0] tick_count_o
);

  state_t      state_q, state_d;
  logic        w_tick;
  logic        w_timer_run;
  logic [23:0] w_period;

  logic        clear_q, clear_d;
  logic        move_start_q, move_start_d;
  logic        coll_start_q, coll_start_d;
  logic        draw_start_q, draw_start_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic        overrun_q, overrun_d;
  logic [15:0] tick_count_q, tick_count_d;

  assign w_period    = calc_period(TICK_PERIOD, SPEED_STEP, MIN_PERIOD, speed_i);
  assign w_timer_run = run_i && (state_q != ST_OVER);

  tick_timer #(
    .RESET_LOAD (TICK_PERIOD - 24'd1)
  ) u_tick_timer (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .run_i    (w_timer_run),
    .period_i (w_period),
    .tick_o   (w_tick)
  );

  always_comb begin
    state_d      = state_q;
    tick_count_d = tick_count_q;
    overrun_d    = overrun_q || (w_tick && (state_q != ST_WAIT));
    if ((state_q != ST_OVER) && !run_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (w_tick) begin
            state_d      = ST_CLEAR;
            tick_count_d = tick_count_q + 16'd1;
          end
        end
        ST_CLEAR: state_d = ST_MOVE;
        ST_MOVE:  if (move_done_i) state_d = ST_COLL;
        ST_COLL:  if (coll_done_i) state_d = coll_hit_i ? ST_OVER : ST_DRAW;
        ST_DRAW:  if (draw_done_i) state_d = ST_WAIT;
        ST_OVER:  state_d = ST_OVER;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    clear_d      = (state_d == ST_CLEAR);
    move_start_d = (state_d == ST_MOVE) && (state_q != ST_MOVE);
    coll_start_d = (state_d == ST_COLL) && (state_q != ST_COLL);
    draw_start_d = (state_d == ST_DRAW) && (state_q != ST_DRAW);
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_MOVE) ||
                   (state_d == ST_COLL)  || (state_d == ST_DRAW);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      clear_q      <= 1'b0;
      move_start_q <= 1'b0;
      coll_start_q <= 1'b0;
      draw_start_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      overrun_q    <= 1'b0;
      tick_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      clear_q      <= clear_d;
      move_start_q <= move_start_d;
      coll_start_q <= coll_start_d;
      draw_start_q <= draw_start_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      overrun_q    <= overrun_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign clear_o      = clear_q;
  assign move_start_o = move_start_q;
  assign coll_start_o = coll_start_q;
  assign draw_start_o = draw_start_q;
  assign busy_o       = busy_q;
  assign game_over_o  = game_over_q;
  assign overrun_o    = overrun_q;
  assign tick_count_o = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_game_tick_scheduler : directed + randomized bench with a phase-level model
// Rev 1.0
// ============================================================================
module tb_game_tick_scheduler;

  localparam logic [23:0] TP = 24'd20;
  localparam logic [23:0] SS = 24'd2;
  localparam logic [23:0] MP = 24'd8;

  localparam int P_IDLE = 0, P_WAIT = 1, P_CLEAR = 2, P_MOVE = 3,
                 P_COLL = 4, P_DRAW = 5, P_OVER = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, move_done, coll_done, coll_hit, draw_done;
  logic [2:0]  speed;
  logic        clear_o, move_start_o, coll_start_o, draw_start_o;
  logic        busy_o, game_over_o, overrun_o;
  logic [15:0] tick_count_o;

  game_tick_scheduler #(
    .TICK_PERIOD (TP),
    .SPEED_STEP  (SS),
    .MIN_PERIOD  (MP)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .run_i        (run),
    .speed_i      (speed),
    .clear_o      (clear_o),
    .move_start_o (move_start_o),
    .move_done_i  (move_done),
    .coll_start_o (coll_start_o),
    .coll_done_i  (coll_done),
    .coll_hit_i   (coll_hit),
    .draw_start_o (draw_start_o),
    .draw_done_i  (draw_done),
    .busy_o       (busy_o),
    .game_over_o  (game_over_o),
    .overrun_o    (overrun_o),
    .tick_count_o (tick_count_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: game phase, edges left until the next tick, counters.
  int m_ph, m_left, m_tc, dly;
  bit m_ovr;
  bit e_clear, e_mv, e_co, e_dr, e_busy, e_over;

  bit auto_resp, noise, rand_dly, hit_next;
  int d_move, d_coll, d_draw;
  int clr_q[$];
  int last_mv, last_co, last_dr;

  function automatic int period_of(input int s);
    int p;
    p = int'(TP) - s * int'(SS);
    if (p < int'(MP)) p = int'(MP);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ":clear"},      32'(clear_o),      32'(e_clear));
    chk({ctx, ":move_start"}, 32'(move_start_o), 32'(e_mv));
    chk({ctx, ":coll_start"}, 32'(coll_start_o), 32'(e_co));
    chk({ctx, ":draw_start"}, 32'(draw_start_o), 32'(e_dr));
    chk({ctx, ":busy"},       32'(busy_o),       32'(e_busy));
    chk({ctx, ":game_over"},  32'(game_over_o),  32'(e_over));
    chk({ctx, ":overrun"},    32'(overrun_o),    32'(m_ovr));
    chk({ctx, ":tick_count"}, 32'(tick_count_o), 32'(m_tc));
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_left = int'(TP); m_tc = 0; m_ovr = 1'b0; dly = 0;
    e_clear = 0; e_mv = 0; e_co = 0; e_dr = 0; e_busy = 0; e_over = 0;
  endtask

  task automatic step();
    int prev;
    bit tk;
    if (auto_resp) begin
      move_done = (m_ph == P_MOVE && dly == 0) || (noise && m_ph != P_MOVE && $urandom_range(0, 7) == 0);
      coll_done = (m_ph == P_COLL && dly == 0) || (noise && m_ph != P_COLL && $urandom_range(0, 7) == 0);
      draw_done = (m_ph == P_DRAW && dly == 0) || (noise && m_ph != P_DRAW && $urandom_range(0, 7) == 0);
      coll_hit  = (m_ph == P_COLL && dly == 0) ? hit_next : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    prev = m_ph;
    tk   = run && (m_ph != P_OVER) && (m_left == 1);
    if (m_ph != P_OVER) begin
      if (!run || m_left == 1) m_left = period_of(int'(speed));
      else                     m_left = m_left - 1;
    end
    if (tk && prev != P_WAIT) m_ovr = 1'b1;
    if (m_ph != P_OVER && !run) m_ph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE:  m_ph = P_WAIT;
        P_WAIT:  if (tk) begin m_ph = P_CLEAR; m_tc = (m_tc + 1) % 65536; end
        P_CLEAR: m_ph = P_MOVE;
        P_MOVE:  if (move_done) m_ph = P_COLL;
        P_COLL:  if (coll_done) m_ph = coll_hit ? P_OVER : P_DRAW;
        P_DRAW:  if (draw_done) m_ph = P_WAIT;
        default: m_ph = m_ph;
      endcase
    end
    e_clear = (m_ph == P_CLEAR);
    e_mv    = (m_ph == P_MOVE) && (prev != P_MOVE);
    e_co    = (m_ph == P_COLL) && (prev != P_COLL);
    e_dr    = (m_ph == P_DRAW) && (prev != P_DRAW);
    e_busy  = (m_ph >= P_CLEAR) && (m_ph <= P_DRAW);
    e_over  = (m_ph == P_OVER);
    if (m_ph != prev)
      dly = rand_dly ? int'($urandom_range(0, 4)) :
            (m_ph == P_MOVE) ? d_move : (m_ph == P_COLL) ? d_coll : d_draw;
    else if (dly > 0)
      dly = dly - 1;
    @(negedge clk);
    cyc++;
    check_outputs("cyc");
    if (clear_o)      clr_q.push_back(cyc);
    if (move_start_o) last_mv = cyc;
    if (coll_start_o) last_co = cyc;
    if (draw_start_o) last_dr = cyc;
  endtask

  task automatic wait_clears(input int n, input int budget);
    int start, k;
    start = clr_q.size();
    k = 0;
    while (clr_q.size() < start + n && k < budget) begin
      step();
      k++;
    end
    chk("wait_clears_in_budget", 32'(clr_q.size() - start >= n), 32'd1);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int k;
    k = 0;
    while (m_ph != ph && k < budget) begin
      step();
      k++;
    end
    chk("wait_phase_in_budget", 32'(m_ph == ph), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r, n, e_tc;
    rst = 1'b1; run = 1'b0; speed = 3'd0;
    move_done = 0; coll_done = 0; coll_hit = 0; draw_done = 0;
    auto_resp = 1; noise = 0; rand_dly = 0; hit_next = 0;
    d_move = 1; d_coll = 1; d_draw = 1;
    last_mv = 0; last_co = 0; last_dr = 0;
    model_reset();
    @(negedge clk);
    check_outputs("por");
    rst = 1'b0;

    // Nominal pacing and handshake order at speed 0
    run = 1'b1;
    r = cyc;
    wait_clears(3, 100);
    chk("first_clear_latency", 32'(clr_q[0] - r), 32'd20);
    chk("interval_a", 32'(clr_q[1] - clr_q[0]), 32'd20);
    chk("interval_b", 32'(clr_q[2] - clr_q[1]), 32'd20);
    chk("tick_count_3", 32'(tick_count_o), 32'd3);
    repeat (6) step();
    chk("order_move", 32'(last_mv - clr_q[$]), 32'd1);
    chk("order_coll", 32'(last_co - last_mv), 32'd2);
    chk("order_draw", 32'(last_dr - last_co), 32'd2);

    // Speed 7 clamps to the floor; speed changes apply from the next reload
    speed = 3'd7;
    wait_clears(3, 100);
    chk("clamp_interval", 32'(clr_q[$] - clr_q[$-1]), 32'd8);
    speed = 3'd0;
    wait_clears(2, 60);
    chk("after_fast_interval", 32'(clr_q[$-1] - clr_q[$-2]), 32'd8);
    chk("back_to_slow", 32'(clr_q[$] - clr_q[$-1]), 32'd20);
    repeat (5) step();
    speed = 3'd3;
    wait_clears(2, 60);
    chk("mid_change_current", 32'(clr_q[$-1] - clr_q[$-2]), 32'd20);
    chk("mid_change_next", 32'(clr_q[$] - clr_q[$-1]), 32'd14);
    chk("no_overrun_yet", 32'(overrun_o), 32'd0);

    // Slow move engine: the tick inside MOVE is dropped
    speed = 3'd0;
    wait_clears(1, 40);
    d_move = 30;
    e_tc = m_tc;
    wait_clears(1, 80);
    chk("overrun_interval", 32'(clr_q[$] - clr_q[$-1]), 32'd40);
    chk("overrun_set", 32'(overrun_o), 32'd1);
    chk("overrun_tc", 32'(tick_count_o), 32'(e_tc + 1));
    d_move = 1;

    // Randomized speeds, delays, run drops and spurious done pulses
    noise = 1; rand_dly = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) run = 1'b0;
      else if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
      step();
    end
    noise = 0; rand_dly = 0; speed = 3'd0; run = 1'b1;

    // Reset in the middle of MOVE, then a stale move_done
    do_reset();
    d_move = 50;
    wait_phase(P_MOVE, 60);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_in_move");
    @(negedge clk);
    rst = 1'b0;
    auto_resp = 0;
    move_done = 1'b1;
    repeat (6) step();
    move_done = 1'b0;
    auto_resp = 1;
    d_move = 1;
    chk("stale_done_busy", 32'(busy_o), 32'd0);

    // Collision ends the game until reset
    hit_next = 1;
    wait_phase(P_OVER, 80);
    chk("game_over_set", 32'(game_over_o), 32'd1);
    n = clr_q.size();
    repeat (60) step();
    chk("no_clear_after_over", 32'(clr_q.size()), 32'(n));
    chk("still_over", 32'(game_over_o), 32'd1);
    hit_next = 0;
    do_reset();

    // Dropping run in DRAW abandons the sequence; restart waits a full period
    d_draw = 10;
    wait_phase(P_DRAW, 80);
    run = 1'b0;
    step();
    chk("run_drop_busy", 32'(busy_o), 32'd0);
    repeat (3) step();
    d_draw = 1;
    run = 1'b1;
    r = cyc;
    wait_clears(1, 40);
    chk("resume_first_clear", 32'(clr_q[$] - r), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 SHALL have parameter TICK_PERIOD, default 24'd10000000, meaning clock cycles per game tick at speed 0.
REQ-002 SHALL have parameter SPEED_STEP, default 24'd1000000, meaning period reduction per speed level.
REQ-003 SHALL have parameter MIN_PERIOD, default 24'd2000000, meaning floor on the computed tick period.
REQ-004 SHALL have ports clock (input, 1, system clock) and reset (input, 1, reset); one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports run (in, 1, enable ticking) and speed (in, 3, speed level 0-7).
REQ-006 SHALL have port clear (out, 1, one-cycle frame-clear pulse at each accepted tick).
REQ-007 SHALL have ports move_start (out, 1) and move_done (in, 1): snake-move engine handshake.
REQ-008 SHALL have ports coll_start (out, 1), coll_done (in, 1) and coll_hit (in, 1, valid with coll_done).
REQ-009 SHALL have ports draw_start (out, 1) and draw_done (in, 1): renderer handshake.
REQ-010 SHALL have outputs busy (1), game_over (1, sticky), overrun (1, sticky) and tick_count (16, accepted ticks).

Function
REQ-011 SHALL contain a 24-bit down-counter reloaded with period-1, period = max(TICK_PERIOD - speed*SPEED_STEP, MIN_PERIOD), 24-bit unsigned arithmetic, no wrap below MIN_PERIOD.
REQ-012 SHALL sample speed only at counter reload; mid-period speed changes take effect next period.
REQ-013 SHALL assert an internal tick for one cycle when the counter reaches 0 while run=1; counter holds at reload value while run=0.
REQ-014 SHALL implement states IDLE, WAIT, CLEAR, MOVE, COLL, DRAW, OVER.
REQ-015 IDLE -> WAIT when run=1; any state except OVER -> IDLE when run=0, abandoning the sequence without pulsing further starts.
REQ-016 WAIT -> CLEAR on tick; CLEAR lasts exactly one cycle with clear=1, tick_count increments (wraps 0xFFFF -> 0).
REQ-017 CLEAR -> MOVE; on MOVE entry move_start pulses one cycle; stays in MOVE until move_done=1.
REQ-018 MOVE -> COLL on move_done; coll_start pulses one cycle on entry; on coll_done: coll_hit=1 -> OVER, else -> DRAW.
REQ-019 DRAW: draw_start pulses one cycle on entry; on draw_done -> WAIT.
REQ-020 A done input arriving in a state that does not expect it SHALL be ignored; a done asserted in the start-pulse cycle SHALL be accepted.
REQ-021 A tick occurring outside WAIT SHALL be dropped, set overrun=1 and not increment tick_count; counter reloads normally.
REQ-022 OVER: game_over=1, no starts, counter stopped; exit only by reset.
REQ-023 busy SHALL be 1 in CLEAR, MOVE, COLL, DRAW, else 0.
REQ-024 Start pulses and clear SHALL be registered outputs, never concurrently high.

Reset
REQ-025 On reset: state IDLE, counter = TICK_PERIOD-1, clear/starts/busy/game_over/overrun = 0, tick_count = 0.
REQ-026 Reset mid-sequence SHALL abandon the handshake immediately; pending done inputs after reset release are ignored.

Structure
REQ-027 State encodings and default period constants SHALL live in shared package snake_pkg.
REQ-028 Period counter SHALL be a sub-module tick_timer (inputs run, period; output tick); FSM in the top.

Verification (TICK_PERIOD=20, SPEED_STEP=2, MIN_PERIOD=8)
REQ-029 run=1, speed=0, dones returned 1 cycle after each start -> clear every 20 cycles, tick_count 1,2,3; order clear, move_start, coll_start, draw_start.
REQ-030 speed=7 -> period clamps to 8 cycles; speed 0->3 mid-period -> current period 20, next 14.
REQ-031 Hold move_done low 30 cycles -> overrun=1, tick_count unchanged by dropped tick, sequence completes after move_done.
REQ-032 coll_hit=1 with coll_done -> OVER, game_over=1, no draw_start, no further clear until reset.
REQ-033 Assert reset during MOVE -> all outputs zero next cycle, state IDLE, late move_done ignored.
REQ-034 run=0 during DRAW -> IDLE, busy=0; run=1 again -> first clear after full 20-cycle period.
